// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler for the E stage: owns HI/LO, computes at issue,
// commits after a fixed latency, and raises the D-stage stall on HI/LO hazards.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    input  logic        D_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;

    md_op_e             op;
    logic               is_mult;
    logic               is_div;
    logic               is_long;

    assign op      = md_op_e'(md_op);
    assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_long = is_mult || is_div;

    // Multiply: extend both operands to 64 bits; the low 64 bits of the
    // product are correct for both signed and unsigned operands.
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    assign a_ext   = (op == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
    assign b_ext   = (op == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
    assign product = a_ext * b_ext;

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of
    // relying on signed-division overflow behaviour.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    assign a_neg       = (op == OP_DIV) && A[31];
    assign b_neg       = (op == OP_DIV) && B[31];
    assign a_mag       = a_neg ? (32'd0 - A) : A;
    assign b_mag       = b_neg ? (32'd0 - B) : B;
    assign div_by_zero = (B == 32'd0);
    assign divisor     = div_by_zero ? 32'd1 : b_mag;
    assign q_mag       = a_mag / divisor;
    assign r_mag       = a_mag % divisor;
    assign quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem         = a_neg ? (32'd0 - r_mag) : r_mag;

    logic [31:0]      issue_hi;
    logic [31:0]      issue_lo;
    logic             issue_wr;
    logic [CNT_W-1:0] issue_cnt;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        issue_hi  = product[63:32];
        issue_lo  = product[31:0];
        issue_wr  = 1'b1;
        issue_cnt = CNT_W'(MULT_CYCLES);
        if (is_div) begin
            issue_hi  = rem;
            issue_lo  = quot;
            issue_wr  = !div_by_zero;
            issue_cnt = CNT_W'(DIV_CYCLES);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would make register order within the block matter.
    // NOTE: pending results are reset too, so a reset mid-operation can never
    // leak a stale result into a later commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_long) begin
                            pend_hi <= issue_hi;
                            pend_lo <= issue_lo;
                            pend_wr <= issue_wr;
                            count   <= issue_cnt;
                            state   <= RUN;
                        end else if (op == OP_MTHI) begin
                            HI <= A;
                        end else if (op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    // Any start seen here is dropped; upstream stall keeps it from happening.
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        pend_wr <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign stall  = D_md_use && (busy || (start && is_long));
    assign md_out = rd_sel ? HI : LO;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: table-driven mult/div vectors through a
// scoreboard, plus hand sequences for stall, mthi, divide-by-zero and reset.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        D_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] md_out;
    logic [31:0] HI;
    logic [31:0] LO;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .rd_sel   (rd_sel),
        .D_md_use (D_md_use),
        .busy     (busy),
        .stall    (stall),
        .md_out   (md_out),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb[$];
    int          n_cmp;
    int          n_fail;
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue a long op, count busy cycles, verify HI/LO hold, then pop the
    // scoreboard when busy drops. inj_cycle>0 fires an mtlo on that busy cycle.
    task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic d_use, input int inj_cycle);
        int   cycles;
        int   stall_cnt;
        res_t r;
        sb.push_back('{hi: exp_hi, lo: exp_lo});
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b; D_md_use = d_use;
        #1;
        check({name, " issue stall"}, {31'd0, stall}, {31'd0, d_use});
        stall_cnt = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        cycles = 0;
        while (busy && cycles < 50) begin
            cycles++;
            if (stall) stall_cnt++;
            check({name, " HI hold"}, HI, model_hi);
            check({name, " LO hold"}, LO, model_lo);
            if (cycles == inj_cycle) begin
                start = 1'b1; md_op = 3'd6; A = 32'h55;
            end
            @(negedge clk);
            start = 1'b0; md_op = 3'd0;
        end
        check({name, " busy cycles"}, cycles, exp_cycles);
        check({name, " stall after busy"}, {31'd0, stall}, 32'd0);
        if (d_use) check({name, " stall cycles"}, stall_cnt, exp_cycles + 1);
        D_md_use = 1'b0;
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard empty at commit", name);
        end else begin
            r = sb.pop_front();
            check({name, " HI"}, HI, r.hi);
            check({name, " LO"}, LO, r.lo);
            model_hi = r.hi;
            model_lo = r.lo;
            rd_sel = 1'b1; #1;
            check({name, " md_out HI"}, md_out, r.hi);
            rd_sel = 1'b0; #1;
            check({name, " md_out LO"}, md_out, r.lo);
        end
    endtask

    task automatic move_to(input string name, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; D_md_use = 1'b1;
        #1;
        check({name, " stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; D_md_use = 1'b0;
        if (op == 3'd5) model_hi = a; else model_lo = a;
        check({name, " busy"}, {31'd0, busy}, 32'd0);
        check({name, " HI"}, HI, model_hi);
        check({name, " LO"}, LO, model_lo);
    endtask

    initial begin
        int busy_seen;
        n_cmp = 0; n_fail = 0;
        model_hi = '0; model_lo = '0;
        reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
        rd_sel = 1'b0; D_md_use = 1'b0;

        vecs[0] = '{"mult -1*2",        3'd1, 32'hFFFF_FFFF, 32'h2,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{"multu ffff*2",     3'd2, 32'hFFFF_FFFF, 32'h2,          5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{"mult -1*-1",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{"multu ffff^2",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4] = '{"mult 2^16*2^16",   3'd1, 32'h0001_0000, 32'h0001_0000,  5,  32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{"mult min*min",     3'd1, 32'h8000_0000, 32'h8000_0000,  5,  32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{"div 7/-2",         3'd3, 32'h0000_0007, 32'hFFFF_FFFE,  10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{"div -7/2",         3'd3, 32'hFFFF_FFF9, 32'h0000_0002,  10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[8] = '{"div min/-1",       3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  10, 32'h0000_0000, 32'h8000_0000};
        vecs[9] = '{"divu 100/7",       3'd4, 32'd100,       32'd7,          10, 32'h0000_0002, 32'h0000_000E};

        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 10; i++)
            run_md(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cycles,
                   vecs[i].hi, vecs[i].lo, 1'b0, 0);

        // Stall across issue + busy, then mthi which must not stall.
        run_md("stall mult", 3'd1, 32'd3, 32'd5, 5, 32'd0, 32'd15, 1'b1, 0);
        move_to("mthi", 3'd5, 32'h1234);
        rd_sel = 1'b1; #1;
        check("mthi md_out", md_out, 32'h1234);
        rd_sel = 1'b0;

        // Divide by zero leaves HI/LO untouched.
        move_to("mthi 11", 3'd5, 32'h11);
        move_to("mtlo 22", 3'd6, 32'h22);
        run_md("divu by 0", 3'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22, 1'b0, 0);

        // Start while busy: the mtlo fired mid-run must be dropped.
        run_md("mult w/ mtlo", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b0, 2);

        // Reset mid-operation discards the pending divide.
        run_md("pre div", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFD, 1'b0, 0);
        @(negedge clk);
        start = 1'b1; md_op = 3'd4; A = 32'd50; B = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        busy_seen = 0;
        while (busy && busy_seen < 3) begin
            busy_seen++;
            @(negedge clk);
        end
        check("busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset HI", HI, 32'd0);
        check("midreset LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("no late commit HI", HI, 32'd0);
            check("no late commit LO", LO, 32'd0);
            check("no late busy", {31'd0, busy}, 32'd0);
        end

        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler attached to the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and sequences the busy period with a cycle counter.
- Owns the HI/LO registers and raises the D-stage stall when a HI/LO-using instruction would collide with an in-flight operation.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  E-stage instruction is an MD op this cycle (already gated by E-stage validity)
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
A  input  32  forwarded rs value from E
B  input  32  forwarded rt value from E
rd_sel  input  1  1 = read HI, 0 = read LO (mfhi/mflo in E)
D_md_use  input  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
busy  output  1  operation in flight
stall  output  1  stall request to PC/D and clear to E
md_out  output  32  combinational HI or LO per rd_sel
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, busy=0, counter=0, pending results=0, state IDLE. Reset mid-operation discards the pending result. No commit occurs.
- FSM states are IDLE and RUN. busy = (state==RUN).
- IDLE, start & md_op in {1..4}, at the rising edge:
  - compute the result from A/B into pending_hi/pending_lo;
  - load counter = MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN: counter decrements each edge. At the edge where counter==1, HI/LO take the pending values and the FSM returns to IDLE.
- busy is therefore high for exactly N consecutive cycles after the issue edge. New HI/LO are visible in the first cycle busy is 0.
- mthi (5) / mtlo (6) with start in IDLE: HI (or LO) = A at the same edge. No busy cycle.
- start while busy: ignored entirely. Upstream stall prevents this case; the bench checks HI/LO unchanged.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B==0, div or divu): operation still runs DIV_CYCLES busy; HI and LO are left unchanged at commit.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- stall = D_md_use & (busy | (start & md_op in {1..4})). Purely combinational. mthi/mtlo in E does not stall D.
- md_out = rd_sel ? HI : LO, combinational from the architectural registers. It never shows pending values.
- The result is computed once at issue (single-cycle datapath, delayed commit). The counter only models latency.

Test Plan:
- Signed multiply: start, mult, A=0xFFFFFFFF, B=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. HI/LO must hold the old value while busy.
- Unsigned multiply: multu, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- Signed divide: div, A=7, B=0xFFFFFFFE (-2) -> busy 10 cycles; LO=0xFFFFFFFD, HI=0x00000001.
- Overflow divide: div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: divu by 0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO still 0x11/0x22.
- Stall and mthi:
  - D_md_use=1 in the issue cycle and all 5 mult busy cycles -> stall=1 for 6 cycles; stall=0 once busy drops.
  - mthi A=0x1234 -> HI=0x1234 next cycle, stall never asserts, and md_out with rd_sel=1 reads 0x1234.
- Reset mid-operation: issue div, drop reset at busy cycle 4 -> busy=0 and HI=LO=0 immediately. After release, no late commit occurs.
- Start while busy: issue mult, then start mtlo A=0x55 while busy -> mtlo ignored; LO gets the mult result only.
